// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer and the opcode-class decoder:
// instruction formats, classes (= IR[6:2]), FSM states, mux selects and trap causes.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_R4 = 3'd6
  } fmt_e;

  typedef enum logic [4:0] {
    CLS_LOAD      = 5'b00000,
    CLS_OP_IMM    = 5'b00100,
    CLS_OP_IMM_32 = 5'b00110,
    CLS_STORE     = 5'b01000,
    CLS_OP        = 5'b01100,
    CLS_LUI       = 5'b01101,
    CLS_OP_32     = 5'b01110,
    CLS_MADD      = 5'b10000,
    CLS_NMSUB     = 5'b10010,
    CLS_BRANCH    = 5'b11000,
    CLS_JALR      = 5'b11001,
    CLS_JAL       = 5'b11011
  } cls_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_REL   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] CAUSE_NONE         = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL      = 2'd1;
  localparam logic [1:0] CAUSE_IF_TIMEOUT   = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TIMEOUT = 2'd3;

  // MADD/NMSUB and any class outside the list above fall through to illegal.
  function automatic logic is_legal(input logic [4:0] cls, input logic [1:0] lo,
                                    input logic rv64);
    logic ok;
    unique case (cls)
      CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JALR, CLS_JAL,
      CLS_OP_IMM, CLS_OP, CLS_LUI:  ok = 1'b1;
      CLS_OP_IMM_32, CLS_OP_32:     ok = rv64;
      default:                      ok = 1'b0;
    endcase
    return ok && (lo == 2'b11);
  endfunction

  function automatic logic uses_imm(input fmt_e fmt);
    return fmt inside {FMT_I, FMT_S, FMT_U, FMT_J};
  endfunction

endpackage

// File: rtl/mctrl_timeout.sv
// Handshake watchdog: loadable 8-bit up-counter; o_expired flags the cycle in
// which the LIMIT-th consecutive enabled cycle is being spent.
module mctrl_timeout #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_en,
  output logic       o_expired
);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = i_en && (r_count == LIMIT - 8'd1);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes, timeout
// and illegal-instruction traps. Define MULTICYCLE_CTRL_PERF_EN for cycle/instret counters.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter bit          RV64        = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] instr_format,
  input  logic [4:0] instr_type,
  input  logic [1:0] ir_lo,
  input  logic       branch_taken,
  output logic       if_req,
  input  logic       if_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       alu_src_b,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state_o
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

  state_e     r_state;
  cls_e       r_cls;
  fmt_e       r_fmt;
  logic       r_taken;
  logic [1:0] r_cause;

  state_e     w_next;
  logic [1:0] w_trap_cause;
  logic       w_expired;
  logic       w_waiting;
  logic       w_state_change;

  assign w_waiting      = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_state_change = (w_next != r_state);

  mctrl_timeout #(.LIMIT(TIMEOUT_LIMIT)) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_state_change),
    .i_load     (1'b0),
    .i_load_val (8'd0),
    .i_en       (w_waiting),
    .o_expired  (w_expired)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_FETCH:  if (if_ack) w_next = ST_DECODE;
                 else if (w_expired) w_next = ST_TRAP;
      ST_DECODE: w_next = is_legal(instr_type, ir_lo, RV64) ? ST_EXEC : ST_TRAP;
      ST_EXEC:   w_next = (r_cls inside {CLS_LOAD, CLS_STORE}) ? ST_MEM : ST_WB;
      ST_MEM:    if (dmem_ack) w_next = ST_WB;
                 else if (w_expired) w_next = ST_TRAP;
      ST_WB:     w_next = ST_FETCH;
      default:   w_next = ST_TRAP;
    endcase
  end

  always_comb begin
    w_trap_cause = CAUSE_ILLEGAL;
    if (r_state == ST_FETCH)    w_trap_cause = CAUSE_IF_TIMEOUT;
    else if (r_state == ST_MEM) w_trap_cause = CAUSE_DMEM_TIMEOUT;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_cls   <= CLS_LOAD;
      r_fmt   <= FMT_R;
      r_taken <= 1'b0;
      r_cause <= CAUSE_NONE;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_cls <= cls_e'(instr_type);
        r_fmt <= fmt_e'(instr_format);
      end
      if (r_state == ST_EXEC) r_taken <= branch_taken;
      if (w_next == ST_TRAP && r_state != ST_TRAP) r_cause <= w_trap_cause;
    end
  end

  // Outputs are gated by rst_n so requests drop the moment reset asserts.
  always_comb begin
    if_req    = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    alu_src_b = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    trap      = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        ST_FETCH: begin
          if_req = 1'b1;
          ir_we  = if_ack;
        end
        ST_EXEC:  alu_src_b = uses_imm(r_fmt);
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (r_cls == CLS_STORE);
        end
        ST_WB: begin
          pc_we = 1'b1;
          unique case (r_cls)
            CLS_OP, CLS_OP_IMM, CLS_OP_32, CLS_OP_IMM_32: rf_we = 1'b1;
            CLS_LOAD: begin rf_we = 1'b1; wb_sel = WB_MEM; end
            CLS_LUI:  begin rf_we = 1'b1; wb_sel = WB_IMM; end
            CLS_JAL:  begin rf_we = 1'b1; wb_sel = WB_PC4; pc_sel = PC_REL;  end
            CLS_JALR: begin rf_we = 1'b1; wb_sel = WB_PC4; pc_sel = PC_JALR; end
            CLS_BRANCH: pc_sel = r_taken ? PC_REL : PC_PLUS4;
            default: ;
          endcase
        end
        ST_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign trap_cause = r_cause;
  assign state_o    = r_state;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (r_state != ST_TRAP) r_cycle_cnt   <= r_cycle_cnt + 32'd1;
      if (r_state == ST_WB)   r_instret_cnt <= r_instret_cnt + 32'd1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule
